// File: rtl/fact_seq.sv
// Factorial sequencer: drives an external 4-bit up/down counter and multiplies
// its count into a running product to produce N! with a GO/DONE handshake.
module fact_seq #(
   parameter int unsigned RES_W = 32,
   parameter int unsigned N_MAX = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             go,
   input  logic [3:0]       n,
   input  logic [3:0]       cnt_q,
   output logic [3:0]       cnt_d,
   output logic             cnt_ld,
   output logic             cnt_ud,
   output logic             cnt_ce,
   output logic [RES_W-1:0] result,
   output logic             done,
   output logic             err,
   output logic             busy
);

   localparam logic [3:0] N_LIM = 4'(N_MAX);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHK,
      S_MUL,
      S_FIN,
      S_FAIL
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [RES_W-1:0] product;
   logic             n_ok;

   assign n_ok = (n <= N_LIM);

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next state and counter strobes; strobes are held off while reset is applied
   always_comb begin
      state_nxt = state;
      cnt_d     = 4'd0;
      cnt_ld    = 1'b0;
      cnt_ud    = 1'b0;
      cnt_ce    = 1'b0;
      case (state)
         S_IDLE: begin
            if (go) begin
               if (n_ok) begin
                  state_nxt = S_CHK;
                  if (!rst) begin
                     cnt_d  = n;
                     cnt_ld = 1'b1;
                     cnt_ce = 1'b1;
                  end
               end else begin
                  state_nxt = S_FAIL;
               end
            end
         end
         S_CHK:   state_nxt = (cnt_q <= 4'd1) ? S_FIN : S_MUL;
         S_MUL: begin
            state_nxt = S_CHK;
            if (!rst) cnt_ce = 1'b1;
         end
         S_FIN, S_FAIL: begin
            if (!go) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Product accumulator and registered status outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         product <= '0;
         result  <= '0;
         done    <= 1'b0;
         err     <= 1'b0;
         busy    <= 1'b0;
      end else begin
         busy <= (state_nxt == S_CHK) || (state_nxt == S_MUL);
         case (state)
            S_IDLE: begin
               if (go) begin
                  done <= 1'b0;
                  err  <= !n_ok;
                  if (n_ok) product <= RES_W'(1);
               end
            end
            S_CHK: begin
               if (cnt_q <= 4'd1) begin
                  result <= product;
                  done   <= 1'b1;
               end
            end
            S_MUL:   product <= product * RES_W'(cnt_q);
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fact_seq.sv
// Directed bench for fact_seq with a behavioural model of the UD_CNT_4 counter.
module tb_fact_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        go;
   logic [3:0]  n;
   logic [3:0]  cnt_q;
   logic [3:0]  cnt_d;
   logic        cnt_ld;
   logic        cnt_ud;
   logic        cnt_ce;
   logic [31:0] result;
   logic        done;
   logic        err;
   logic        busy;
   logic        rst_n;

   int checks   = 0;
   int failures = 0;
   int ld_cnt   = 0;
   int dec_cnt  = 0;
   int ld_base;
   int dec_base;

   always #5 clk = ~clk;

   fact_seq #(.RES_W(32), .N_MAX(12)) dut (
      .clk    (clk),
      .rst    (rst),
      .go     (go),
      .n      (n),
      .cnt_q  (cnt_q),
      .cnt_d  (cnt_d),
      .cnt_ld (cnt_ld),
      .cnt_ud (cnt_ud),
      .cnt_ce (cnt_ce),
      .result (result),
      .done   (done),
      .err    (err),
      .busy   (busy)
   );

   // UD_CNT_4 model, active-low reset
   assign rst_n = ~rst;
   always @(posedge clk) begin
      if (!rst_n)      cnt_q <= 4'd0;
      else if (cnt_ce) cnt_q <= cnt_ld ? cnt_d : (cnt_ud ? cnt_q + 4'd1 : cnt_q - 4'd1);
   end

   // Strobe counters
   always @(posedge clk) begin
      if (cnt_ld)      ld_cnt  = ld_cnt + 1;
      else if (cnt_ce) dec_cnt = dec_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks = checks + 1;
      if (got !== exp) begin
         failures = failures + 1;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge of cycle 1 after the accepting edge
   task automatic start(input logic [3:0] nv, input bit hold);
      ld_base  = ld_cnt;
      dec_base = dec_cnt;
      n  = nv;
      go = 1'b1;
      @(negedge clk);
      if (!hold) go = 1'b0;
   endtask

   task automatic wait_done(input int cyc0, input int exp_cyc, input string tag);
      int cyc;
      cyc = cyc0;
      while (!done && cyc < 100) begin
         @(negedge clk);
         cyc = cyc + 1;
      end
      check({tag, "_latency"}, 32'(cyc), 32'(exp_cyc));
   endtask

   task automatic run(input logic [3:0] nv, input int exp_cyc, input logic [31:0] exp_res,
                      input int exp_dec, input string tag);
      start(nv, 1'b0);
      wait_done(1, exp_cyc, tag);
      check({tag, "_result"}, result, exp_res);
      check({tag, "_ld_pulses"}, 32'(ld_cnt - ld_base), 32'd1);
      check({tag, "_dec_pulses"}, 32'(dec_cnt - dec_base), 32'(exp_dec));
      check({tag, "_err"}, 32'(err), 32'd0);
      check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
      @(negedge clk);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      go  = 1'b0;
      n   = 4'd0;
      repeat (3) @(negedge clk);

      check("rst_result", result, 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_strobes", 32'({cnt_ld, cnt_ce, cnt_ud}), 32'd0);
      check("rst_cnt_d", 32'(cnt_d), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // N=5: busy during the run, 120 after 10 cycles
      start(4'd5, 1'b0);
      check("n5_busy", 32'(busy), 32'd1);
      check("n5_cnt_q_loaded", 32'(cnt_q), 32'd5);
      wait_done(1, 10, "n5");
      check("n5_result", result, 32'd120);
      check("n5_dec_pulses", 32'(dec_cnt - dec_base), 32'd4);
      check("n5_cnt_q_final", 32'(cnt_q), 32'd1);
      repeat (3) @(negedge clk);
      check("n5_done_persist", 32'(done), 32'd1);

      // Out-of-range operand
      start(4'd13, 1'b1);
      check("n13_err", 32'(err), 32'd1);
      check("n13_done", 32'(done), 32'd0);
      check("n13_result", result, 32'd120);
      check("n13_busy", 32'(busy), 32'd0);
      repeat (2) @(negedge clk);
      check("n13_no_ld", 32'(ld_cnt - ld_base), 32'd0);
      go = 1'b0;
      repeat (2) @(negedge clk);
      check("n13_err_held", 32'(err), 32'd1);

      run(4'd0, 2, 32'd1, 0, "n0");
      run(4'd1, 2, 32'd1, 0, "n1");
      run(4'd12, 24, 32'd479001600, 11, "n12");

      // Reset during an N=7 run
      start(4'd7, 1'b0);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_result", result, 32'd0);
      check("mid_rst_done", 32'(done), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_strobes", 32'({cnt_ld, cnt_ce, cnt_ud}), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      run(4'd3, 6, 32'd6, 2, "n3");

      // GO held high and re-pulsed while busy, then held through FIN
      start(4'd4, 1'b1);
      @(negedge clk);
      @(negedge clk);
      go = 1'b0;
      @(negedge clk);
      go = 1'b1;
      wait_done(4, 8, "n4_hold");
      check("n4_hold_result", result, 32'd24);
      repeat (5) @(negedge clk);
      check("n4_hold_done", 32'(done), 32'd1);
      check("n4_hold_busy", 32'(busy), 32'd0);
      check("n4_hold_one_ld", 32'(ld_cnt - ld_base), 32'd1);
      check("n4_hold_result_kept", result, 32'd24);
      go = 1'b0;
      @(negedge clk);
      run(4'd2, 4, 32'd2, 1, "n2_after_hold");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
